cond_unit_mc: RTL and testbench

- Parametrised, multi-context successor to the execute-stage condition logic.
- Holds one NZCV flag bank per hardware context and evaluates a 4-bit condition field against the selected bank.
- Gates register write, memory write, branch (PCSrc) and post-ALU mux select on the condition result.
- After every taken branch, squashes a configurable number of shadow instructions with a down-counter.

---
 rtl/cond_unit_mc_if.sv | 34 +++
 rtl/cond_unit_mc.sv | 103 ++++++++++
 tb/tb_cond_unit_mc.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cond_unit_mc_if.sv
// Execute-stage condition bus: instruction fields and flags in, gated controls out.
// All signals belong to the current execute cycle; there is no valid/ready handshake.
interface cond_unit_mc_if #(
  parameter int CTX_W = 1
);
  logic             stall;
  logic [CTX_W-1:0] ctxSel;
  logic [3:0]       cond;
  logic [1:0]       flagUpdate;
  logic [3:0]       aluFlags;
  logic             PCS;
  logic             regW;
  logic             memWriteSrc;
  logic             postSelReq;

  logic             PCSrc;
  logic             RegWrite;
  logic             memWrite;
  logic             postAluMuxSel;
  logic [3:0]       flagsOut;
  logic             squash;
  // Debug view of the shadow-squash down-counter.
  logic [2:0]       squashCnt;

  modport master (
    output stall, ctxSel, cond, flagUpdate, aluFlags, PCS, regW, memWriteSrc, postSelReq,
    input  PCSrc, RegWrite, memWrite, postAluMuxSel, flagsOut, squash, squashCnt
  );

  modport slave (
    input  stall, ctxSel, cond, flagUpdate, aluFlags, PCS, regW, memWriteSrc, postSelReq,
    output PCSrc, RegWrite, memWrite, postAluMuxSel, flagsOut, squash, squashCnt
  );
endinterface

// File: rtl/cond_unit_mc.sv
// Multi-context condition unit: per-context NZCV banks, ARM condition evaluation,
// gated write/branch controls and a post-branch shadow-squash counter.
module cond_unit_mc #(
  parameter int NCTX        = 2,
  parameter int CTX_W       = (NCTX > 1) ? $clog2(NCTX) : 1,
  parameter int FLUSH_DEPTH = 2,
  parameter bit BYPASS      = 1'b1
) (
  input logic              clk,
  input logic              reset,
  cond_unit_mc_if.slave    bus
);

  logic [3:0]       bank_q [NCTX];
  logic [3:0]       bank_d [NCTX];
  logic [2:0]       cnt_q;
  logic [2:0]       cnt_d;
  logic [CTX_W-1:0] ctx;
  logic [3:0]       eff;
  logic             n_f, z_f, c_f, v_f;
  logic             cond_pass;
  logic             squash;
  logic             live;
  logic             pc_src;

  // Out-of-range context selects alias onto context 0.
  always_comb begin
    ctx = '0;
    if (32'(bus.ctxSel) < NCTX) ctx = bus.ctxSel;
  end

  always_comb begin
    eff = bank_q[ctx];
    if (BYPASS && bus.flagUpdate[1]) eff[3:2] = bus.aluFlags[3:2];
    if (BYPASS && bus.flagUpdate[0]) eff[1:0] = bus.aluFlags[1:0];
  end

  assign n_f = eff[3];
  assign z_f = eff[2];
  assign c_f = eff[1];
  assign v_f = eff[0];

  always_comb begin
    cond_pass = 1'b0;
    case (bus.cond)
      4'h0: cond_pass = z_f;
      4'h1: cond_pass = ~z_f;
      4'h2: cond_pass = c_f;
      4'h3: cond_pass = ~c_f;
      4'h4: cond_pass = n_f;
      4'h5: cond_pass = ~n_f;
      4'h6: cond_pass = v_f;
      4'h7: cond_pass = ~v_f;
      4'h8: cond_pass = c_f & ~z_f;
      4'h9: cond_pass = ~c_f | z_f;
      4'hA: cond_pass = (n_f == v_f);
      4'hB: cond_pass = (n_f != v_f);
      4'hC: cond_pass = ~z_f & (n_f == v_f);
      4'hD: cond_pass = z_f | (n_f != v_f);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign squash = (cnt_q != 3'd0);
  assign live   = cond_pass & ~squash & ~bus.stall;
  assign pc_src = bus.PCS & live;

  // Outputs are forced low while reset is held, even though they are combinational.
  assign bus.PCSrc         = pc_src & reset;
  assign bus.RegWrite      = bus.regW & live & reset;
  assign bus.memWrite      = bus.memWriteSrc & live & reset;
  assign bus.postAluMuxSel = bus.postSelReq & live & reset;
  assign bus.flagsOut      = reset ? eff : 4'b0000;
  assign bus.squash        = squash;
  assign bus.squashCnt     = cnt_q;

  always_comb begin
    bank_d = bank_q;
    if (live && bus.flagUpdate[1]) bank_d[ctx][3:2] = bus.aluFlags[3:2];
    if (live && bus.flagUpdate[0]) bank_d[ctx][1:0] = bus.aluFlags[1:0];
  end

  // A taken branch cannot coincide with an active squash, so load never races decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (!bus.stall) begin
      if (pc_src)             cnt_d = 3'(FLUSH_DEPTH);
      else if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q <= '{default: 4'b0000};
      cnt_q  <= 3'd0;
    end else begin
      bank_q <= bank_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cond_unit_mc.sv
// Bench for cond_unit_mc: one instance with bypass and a two-cycle squash,
// one with registered-only flags and no squash, both fed the same directed vectors.
module tb_cond_unit_mc;

  localparam int W = 9;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       ctx_sel;
  logic [3:0] cond;
  logic [1:0] flag_update;
  logic [3:0] alu_flags;
  logic       pcs, reg_w, mem_w, post_req;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_b_q[$];
  string        name_q[$];
  int           checks;
  int           errors;

  cond_unit_mc_if #(.CTX_W(1)) bus_a ();
  cond_unit_mc_if #(.CTX_W(1)) bus_b ();

  cond_unit_mc #(.NCTX(2), .FLUSH_DEPTH(2), .BYPASS(1'b1)) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_a.slave)
  );

  cond_unit_mc #(.NCTX(2), .FLUSH_DEPTH(0), .BYPASS(1'b0)) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_b.slave)
  );

  assign bus_a.stall = stall;        assign bus_b.stall = stall;
  assign bus_a.ctxSel = ctx_sel;     assign bus_b.ctxSel = ctx_sel;
  assign bus_a.cond = cond;          assign bus_b.cond = cond;
  assign bus_a.flagUpdate = flag_update; assign bus_b.flagUpdate = flag_update;
  assign bus_a.aluFlags = alu_flags; assign bus_b.aluFlags = alu_flags;
  assign bus_a.PCS = pcs;            assign bus_b.PCS = pcs;
  assign bus_a.regW = reg_w;         assign bus_b.regW = reg_w;
  assign bus_a.memWriteSrc = mem_w;  assign bus_b.memWriteSrc = mem_w;
  assign bus_a.postSelReq = post_req; assign bus_b.postSelReq = post_req;

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; ctx_sel = 1'b0; cond = 4'h0;
    flag_update = 2'b00; alu_flags = 4'h0;
    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; post_req = 1'b0;
  end

  // Driver: ctl = {PCS, regW, memWriteSrc, postSelReq};
  // expected = {PCSrc, RegWrite, memWrite, postAluMuxSel, flagsOut[3:0], squash}
  task automatic step(input string nm, input logic rst, input logic st, input logic cx,
                      input logic [3:0] cd, input logic [1:0] fu, input logic [3:0] af,
                      input logic [3:0] ctl, input logic [W-1:0] ea, input logic [W-1:0] eb);
    @(posedge clk);
    #1;
    rst_n = rst; stall = st; ctx_sel = cx; cond = cd; flag_update = fu; alu_flags = af;
    {pcs, reg_w, mem_w, post_req} = ctl;
    exp_q.push_back(ea);
    exp_b_q.push_back(eb);
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  initial begin
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [W-1:0] ea, eb, aa, ab;
        string nm;
        ea = exp_q.pop_front();
        eb = exp_b_q.pop_front();
        nm = name_q.pop_front();
        aa = {bus_a.PCSrc, bus_a.RegWrite, bus_a.memWrite, bus_a.postAluMuxSel,
              bus_a.flagsOut, bus_a.squash};
        ab = {bus_b.PCSrc, bus_b.RegWrite, bus_b.memWrite, bus_b.postAluMuxSel,
              bus_b.flagsOut, bus_b.squash};
        checks++;
        if (aa !== ea) begin
          errors++;
          $display("FAIL %s[bypass] got %b expected %b", nm, aa, ea);
        end
        checks++;
        if (ab !== eb) begin
          errors++;
          $display("FAIL %s[nobypass] got %b expected %b", nm, ab, eb);
        end
      end
    end
  end

  // Stimulus
  initial begin
    //   name            rst  st   ctx  cond  fu     alu      ctl      exp_bypass      exp_nobypass
    step("in_reset",    1'b0,1'b0,1'b0,4'hE,2'b11,4'b1111,4'b1111,9'b0000_0000_0,9'b0000_0000_0);
    step("eq_after_rst",1'b1,1'b0,1'b0,4'h0,2'b00,4'b0000,4'b0100,9'b0000_0000_0,9'b0000_0000_0);
    step("al_after_rst",1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b0100,9'b0100_0000_0,9'b0100_0000_0);
    step("wr_ctx0_z",   1'b1,1'b0,1'b0,4'hE,2'b11,4'b0100,4'b0000,9'b0000_0100_0,9'b0000_0000_0);
    step("eq_ctx0",     1'b1,1'b0,1'b0,4'h0,2'b00,4'b0000,4'b0100,9'b0100_0100_0,9'b0100_0100_0);
    step("eq_ctx1_iso", 1'b1,1'b0,1'b1,4'h0,2'b00,4'b0000,4'b0100,9'b0000_0000_0,9'b0000_0000_0);
    step("ge_bypass",   1'b1,1'b0,1'b1,4'hA,2'b11,4'b1001,4'b0110,9'b0110_1001_0,9'b0110_0000_0);
    step("lt_ctx1",     1'b1,1'b0,1'b1,4'hB,2'b00,4'b0000,4'b0100,9'b0000_1001_0,9'b0000_1001_0);
    step("eq_fail_nowr",1'b1,1'b0,1'b1,4'h0,2'b11,4'b0010,4'b0100,9'b0000_0010_0,9'b0000_1001_0);
    step("post_ctx1",   1'b1,1'b0,1'b1,4'hE,2'b00,4'b0000,4'b0001,9'b0001_1001_0,9'b0001_1001_0);
    step("never",       1'b1,1'b0,1'b0,4'hF,2'b00,4'b0000,4'b0100,9'b0000_0100_0,9'b0000_0100_0);
    step("ls_pass",     1'b1,1'b0,1'b0,4'h9,2'b00,4'b0000,4'b0010,9'b0010_0100_0,9'b0010_0100_0);
    step("br_taken",    1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b1100,9'b1100_0100_0,9'b1100_0100_0);
    step("squash_t1",   1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b0110,9'b0000_0100_1,9'b0110_0100_0);
    step("squash_t2",   1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b0110,9'b0000_0100_1,9'b0110_0100_0);
    step("squash_end",  1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b0110,9'b0110_0100_0,9'b0110_0100_0);
    step("br2_taken",   1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b1000,9'b1000_0100_0,9'b1000_0100_0);
    step("stall_sq",    1'b1,1'b1,1'b0,4'hE,2'b00,4'b0000,4'b0100,9'b0000_0100_1,9'b0000_0100_0);
    step("stall_sq_t2", 1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b0100,9'b0000_0100_1,9'b0100_0100_0);
    step("stall_sq_t3", 1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b0100,9'b0000_0100_1,9'b0100_0100_0);
    step("stall_sq_end",1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b0100,9'b0100_0100_0,9'b0100_0100_0);
    step("stall_br",    1'b1,1'b1,1'b0,4'hE,2'b00,4'b0000,4'b1100,9'b0000_0100_0,9'b0000_0100_0);
    step("after_stbr",  1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b0100,9'b0100_0100_0,9'b0100_0100_0);
    step("br3_taken",   1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b1000,9'b1000_0100_0,9'b1000_0100_0);
    step("rst_mid_sq",  1'b0,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b0100,9'b0000_0000_0,9'b0000_0000_0);
    step("wr_z_post",   1'b1,1'b0,1'b0,4'hE,2'b10,4'b0100,4'b0000,9'b0000_0100_0,9'b0000_0000_0);
    step("ne_fail",     1'b1,1'b0,1'b0,4'h1,2'b11,4'b0110,4'b0010,9'b0000_0110_0,9'b0000_0100_0);
    step("bank_kept",   1'b1,1'b0,1'b0,4'hE,2'b00,4'b0000,4'b0100,9'b0100_0100_0,9'b0100_0100_0);
    step("ctx1_cleared",1'b1,1'b0,1'b1,4'hE,2'b00,4'b0000,4'b0000,9'b0000_0000_0,9'b0000_0000_0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
